spi_master: RTL

Host-side SPI master that drives 32-bit command frames to the register-mapped UART SPI slave (SPI mode 0, LSB first, full duplex). It accepts register write/read requests on a valid/ready interface and serialises each as {cmd[7:0], addr[7:0], data[15:0]}. Reads take two frames: a read-command frame, then a NOP response frame whose MISO bits form the returned word. It sits in the host/test-harness side of the UART subsystem, opposite the spi_ctl slave.

---
 rtl/spi_master_pkg.sv | 50 +++++
 rtl/spi_frame_engine.sv | 121 ++++++++++++
 rtl/spi_master.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_pkg
// Shared constants and types for the host-side SPI master. It holds the
// command bytes, the register map of the UART SPI slave, the frame-engine
// phase enum and the request-sequencer enum. It also provides a helper that
// packs a request into its 32-bit frame word.
// ---------------------------------------------------------------------------
package spi_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_NOP   = 8'hFF;

    localparam logic [7:0] REG_CONTROL = 8'h00;
    localparam logic [7:0] REG_STATE   = 8'h08;
    localparam logic [7:0] REG_TX_DATA = 8'h10;
    localparam logic [7:0] REG_RX_DATA = 8'h18;
    localparam logic [7:0] REG_BAUD    = 8'h20;

    // The response frame of a read carries no command for the slave.
    localparam logic [31:0] NOP_FRAME = {CMD_NOP, 24'h00_0000};

    // Phases of a transaction. The frame engine walks IDLE/SETUP/HIGH/LOW.
    // The sequencer covers the inter-frame GAP and the RESP pulse.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP,
        RESP
    } state_t;

    // Request sequencer states in the top level. SEQ_FRAME means the frame
    // engine currently owns the bus.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FRAME,
        SEQ_GAP,
        SEQ_RESP
    } seq_t;

    // Pack a request as {cmd, addr, data}. Bit 0 goes out first on the wire.
    function automatic logic [31:0] build_frame(input logic       write,
                                                input logic [7:0]  addr,
                                                input logic [15:0] wdata);
        return write ? {CMD_WRITE, addr, wdata} : {CMD_READ, addr, 16'h0000};
    endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// ---------------------------------------------------------------------------
// spi_frame_engine
// Shifts one 32-bit full-duplex SPI frame in mode 0, LSB first.
// A frame is one SETUP phase followed by 32 HIGH/LOW pairs. Each phase lasts
// CLK_DIV clk cycles, so cs_n is low for CLK_DIV*65 cycles.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        load frame_in and begin a frame (honoured only in IDLE)
//   frame_in     32-bit word to transmit
//   done         high in the last clk cycle of the frame
//   capture      bits sampled from miso; bit k comes from SCK pulse k
//   sck, cs_n    SPI clock (idles 0) and chip select (idles 1)
//   mosi         master data out; 0 while cs_n is high
//   miso         slave data in; sampled directly
// ---------------------------------------------------------------------------
module spi_frame_engine
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] frame_in,
    output logic        done,
    output logic [31:0] capture,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [4:0]         bit_cnt;
    logic [31:0]        frame;
    logic               div_last;
    logic [4:0]         tx_sel;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Phase register. On reset the engine returns to IDLE, which releases
    // cs_n and sck immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-phase logic. Each phase lasts one full divider period. The frame
    // ends after the LOW phase of bit 31.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = SETUP;
            SETUP: if (div_last) state_next = HIGH;
            HIGH:  if (div_last) state_next = LOW;
            LOW: begin
                if (div_last) begin
                    if (bit_cnt == 5'd31) begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end else begin
                        state_next = HIGH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. The divider restarts on every phase change. The bit counter
    // advances at the end of each LOW phase except the last one. miso is
    // taken on the final HIGH cycle, just before SCK falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= 5'd0;
            frame   <= 32'h0000_0000;
            capture <= 32'h0000_0000;
        end else begin
            if (state == IDLE || state_next != state) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (state == IDLE && start) begin
                bit_cnt <= 5'd0;
                frame   <= frame_in;
            end else if (state == LOW && div_last && bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (state == HIGH && div_last) begin
                capture[bit_cnt] <= miso;
            end
        end
    end

    // During LOW the next bit is already presented, so it is stable at the
    // following rising edge. After bit 31 the last bit is simply held.
    always_comb begin
        tx_sel = bit_cnt;
        if (state == LOW && bit_cnt != 5'd31) begin
            tx_sel = bit_cnt + 5'd1;
        end
    end

    assign sck  = (state == HIGH);
    assign cs_n = (state == IDLE);
    assign mosi = (state == IDLE) ? 1'b0 : frame[tx_sel];

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// Host-side SPI master for the register-mapped UART SPI slave.
// Each accepted request goes out as a 32-bit frame {cmd, addr, data}.
// A read is followed, after a one-cycle cs_n gap, by a NOP frame; the miso
// bits of that NOP frame form the returned word. Every transaction ends with
// at least IDLE_GAP cycles of cs_n high, then a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   req_valid/ready     request handshake; ready only while idle
//   req_write           1 = register write, 0 = register read
//   req_addr, req_wdata register address and write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           read data (0 for writes), held until next response
//   busy                high from acceptance through rsp_valid
//   sck, cs_n, mosi     SPI outputs
//   miso                SPI input
// ---------------------------------------------------------------------------
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int READ_GAP = 1,
    parameter int IDLE_GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int GAP_W = $clog2(IDLE_GAP + READ_GAP + 1) + 1;

    seq_t               seq;
    seq_t               seq_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic               is_read;
    logic               cmd_pending;
    logic               start;
    logic [31:0]        frame_in;
    logic               frame_done;
    logic [31:0]        capture;

    spi_frame_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .frame_in (frame_in),
        .done     (frame_done),
        .capture  (capture),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq <= SEQ_IDLE;
        end else begin
            seq <= seq_next;
        end
    end

    // Request sequencing. A read whose command frame has just finished does
    // not go to RESP. It restarts the engine with a NOP frame after READ_GAP
    // cycles, so the next cs_n fall lands in the slave's response-load
    // window.
    always_comb begin
        seq_next = seq;
        start    = 1'b0;
        frame_in = build_frame(req_write, req_addr, req_wdata);
        case (seq)
            SEQ_IDLE: begin
                if (req_valid) begin
                    start    = 1'b1;
                    seq_next = SEQ_FRAME;
                end
            end
            SEQ_FRAME: begin
                if (frame_done) seq_next = SEQ_GAP;
            end
            SEQ_GAP: begin
                if (cmd_pending) begin
                    if (gap_cnt == GAP_W'(READ_GAP - 1)) begin
                        start    = 1'b1;
                        frame_in = NOP_FRAME;
                        seq_next = SEQ_FRAME;
                    end
                end else if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
                    seq_next = SEQ_RESP;
                end
            end
            SEQ_RESP: seq_next = SEQ_IDLE;
            default:  seq_next = SEQ_IDLE;
        endcase
    end

    // Bookkeeping for the gap counter, read tracking and the response word.
    // rsp_rdata is loaded when leaving GAP so that it is valid during the
    // rsp_valid cycle, and it is held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt     <= '0;
            is_read     <= 1'b0;
            cmd_pending <= 1'b0;
            rsp_rdata   <= 32'h0000_0000;
        end else begin
            if (seq_next != seq) begin
                gap_cnt <= '0;
            end else if (seq == SEQ_GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            if (seq == SEQ_IDLE && req_valid) begin
                is_read     <= ~req_write;
                cmd_pending <= ~req_write;
            end else if (seq == SEQ_GAP && seq_next == SEQ_FRAME) begin
                cmd_pending <= 1'b0;
            end

            if (seq == SEQ_GAP && seq_next == SEQ_RESP) begin
                rsp_rdata <= is_read ? capture : 32'h0000_0000;
            end
        end
    end

    assign req_ready = (seq == SEQ_IDLE);
    assign busy      = (seq != SEQ_IDLE);
    assign rsp_valid = (seq == SEQ_RESP);

endmodule
